hood_mode_scheduler: RTL and testbench

Sequencing controller for the range-hood fan datapath: turns debounced menu/gear/clean button pulses and a 1 Hz tick into the 3-bit fan mode that drives the smoker display/LED datapath. Enforces menu-gated mode entry, the timed hurricane (gear 3) run with automatic fall-back to gear 2, the delayed hurricane exit, and the timed self-clean cycle. Sits between the on/off controller (`power_on`) and the smoker datapath (`mode_state`).

---
 rtl/hood_mode_scheduler.sv | 239 +++++++++++++++++++++++
 tb/tb_hood_mode_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hood_mode_scheduler.sv
// -----------------------------------------------------------------------------
// hood_mode_scheduler
//
// Fan-mode sequencer for the range hood. It turns debounced button pulses and
// a 1 Hz tick into the 3-bit fan mode for the smoker display/LED datapath.
// It handles:
//   - menu-gated mode entry from standby
//   - direct gear switching while a gear runs
//   - a timed hurricane run with automatic fall-back to gear 2
//   - a timed hurricane exit to standby
//   - a timed self-clean cycle
//
// Optional feature macro: HOOD_HURRICANE_ONCE_EN
//   defined     -> hurricane may run only once per power session
//   not defined -> hurricane_used reads 0 and mode3 is always accepted
//
// Parameters:
//   HURRICANE_SEC  hurricane run length in seconds (1..255)
//   EXIT_SEC       hurricane-exit delay to standby in seconds (1..255)
//   CLEAN_SEC      self-clean duration in seconds (1..255)
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   tick_1hz       one-cycle pulse once per second
//   power_on       machine-on level; 0 forces standby and clears the session
//   menu_btn       debounced one-cycle pulse
//   mode1_btn      debounced one-cycle pulse, gear 1
//   mode2_btn      debounced one-cycle pulse, gear 2
//   mode3_btn      debounced one-cycle pulse, hurricane
//   clean_btn      debounced one-cycle pulse, self-clean
//   mode_state     000 standby, 001 gear1, 010 gear2, 011 hurricane, 100 clean
//   menu_led       menu armed
//   countdown      remaining seconds of the active timed phase, else 0
//   busy           timed phase active (hurricane, hurricane exit, clean)
//   hurricane_used hurricane already run in this power session
//   clean_done     one-cycle pulse when self-clean completes
// -----------------------------------------------------------------------------
module hood_mode_scheduler #(
    parameter int HURRICANE_SEC = 60,
    parameter int EXIT_SEC      = 60,
    parameter int CLEAN_SEC     = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       power_on,
    input  logic       menu_btn,
    input  logic       mode1_btn,
    input  logic       mode2_btn,
    input  logic       mode3_btn,
    input  logic       clean_btn,
    output logic [2:0] mode_state,
    output logic       menu_led,
    output logic [7:0] countdown,
    output logic       busy,
    output logic       hurricane_used,
    output logic       clean_done
);

    typedef enum logic [2:0] {
        ST_STANDBY,
        ST_GEAR1,
        ST_GEAR2,
        ST_HURRI,
        ST_HURRI_EXIT,
        ST_CLEAN
    } state_t;

    localparam logic [2:0] MODE_STANDBY = 3'b000;
    localparam logic [2:0] MODE_GEAR1   = 3'b001;
    localparam logic [2:0] MODE_GEAR2   = 3'b010;
    localparam logic [2:0] MODE_HURRI   = 3'b011;
    localparam logic [2:0] MODE_CLEAN   = 3'b100;

    localparam logic [7:0] HURRI_LOAD = 8'(HURRICANE_SEC);
    localparam logic [7:0] EXIT_LOAD  = 8'(EXIT_SEC);
    localparam logic [7:0] CLEAN_LOAD = 8'(CLEAN_SEC);

    state_t     r_state;
    logic [2:0] r_mode_state;
    logic       r_menu_led;
    logic [7:0] r_countdown;
    logic       r_busy;
    logic       r_clean_done;

    logic       w_hurri_allowed;
    logic       w_mode3_ok;
    logic       w_tick_last;
    logic       w_tick_dec;

`ifdef HOOD_HURRICANE_ONCE_EN
    logic       r_hurricane_used;
    assign w_hurri_allowed = ~r_hurricane_used;
    assign hurricane_used  = r_hurricane_used;
`else
    assign w_hurri_allowed = 1'b1;
    assign hurricane_used  = 1'b0;
`endif

    // A blocked mode3 press is treated as no press at all.
    // A lower-priority clean press in the same cycle is therefore still honoured.
    assign w_mode3_ok  = mode3_btn & w_hurri_allowed;

    // The tick that ends a timed phase.
    // A tick at 0 cannot end a phase; it only holds the countdown at 0.
    assign w_tick_last = tick_1hz & (r_countdown == 8'd1);
    assign w_tick_dec  = tick_1hz & (r_countdown != 8'd0);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        // Every branch then reads this cycle's register values.
        // The default below makes clean_done a single-cycle pulse.
        // Only the clean-completion branch overrides it.
        r_clean_done <= 1'b0;

        if (rst || !power_on) begin
            r_state      <= ST_STANDBY;
            r_mode_state <= MODE_STANDBY;
            r_menu_led   <= 1'b0;
            r_countdown  <= 8'd0;
            r_busy       <= 1'b0;
`ifdef HOOD_HURRICANE_ONCE_EN
            r_hurricane_used <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_STANDBY: begin
                    // A menu press takes the cycle.
                    // Any mode press arriving with it is dropped.
                    if (menu_btn) begin
                        r_menu_led <= ~r_menu_led;
                    end else if (r_menu_led) begin
                        if (mode1_btn) begin
                            r_menu_led   <= 1'b0;
                            r_state      <= ST_GEAR1;
                            r_mode_state <= MODE_GEAR1;
                        end else if (mode2_btn) begin
                            r_menu_led   <= 1'b0;
                            r_state      <= ST_GEAR2;
                            r_mode_state <= MODE_GEAR2;
                        end else if (w_mode3_ok) begin
                            r_menu_led   <= 1'b0;
                            r_state      <= ST_HURRI;
                            r_mode_state <= MODE_HURRI;
                            r_countdown  <= HURRI_LOAD;
                            r_busy       <= 1'b1;
`ifdef HOOD_HURRICANE_ONCE_EN
                            r_hurricane_used <= 1'b1;
`endif
                        end else if (clean_btn) begin
                            r_menu_led   <= 1'b0;
                            r_state      <= ST_CLEAN;
                            r_mode_state <= MODE_CLEAN;
                            r_countdown  <= CLEAN_LOAD;
                            r_busy       <= 1'b1;
                        end
                    end
                end

                ST_GEAR1, ST_GEAR2: begin
                    // Gears switch without arming the menu.
                    // The clean button is not honoured from a gear.
                    if (menu_btn) begin
                        r_state      <= ST_STANDBY;
                        r_mode_state <= MODE_STANDBY;
                    end else if (mode1_btn) begin
                        r_state      <= ST_GEAR1;
                        r_mode_state <= MODE_GEAR1;
                    end else if (mode2_btn) begin
                        r_state      <= ST_GEAR2;
                        r_mode_state <= MODE_GEAR2;
                    end else if (w_mode3_ok) begin
                        r_state      <= ST_HURRI;
                        r_mode_state <= MODE_HURRI;
                        r_countdown  <= HURRI_LOAD;
                        r_busy       <= 1'b1;
`ifdef HOOD_HURRICANE_ONCE_EN
                        r_hurricane_used <= 1'b1;
`endif
                    end
                end

                ST_HURRI: begin
                    // An exit request beats an expiring tick in the same cycle.
                    if (menu_btn) begin
                        r_state     <= ST_HURRI_EXIT;
                        r_countdown <= EXIT_LOAD;
                    end else if (w_tick_last) begin
                        r_state      <= ST_GEAR2;
                        r_mode_state <= MODE_GEAR2;
                        r_countdown  <= 8'd0;
                        r_busy       <= 1'b0;
                    end else if (w_tick_dec) begin
                        r_countdown <= r_countdown - 8'd1;
                    end
                end

                ST_HURRI_EXIT: begin
                    if (w_tick_last) begin
                        r_state      <= ST_STANDBY;
                        r_mode_state <= MODE_STANDBY;
                        r_countdown  <= 8'd0;
                        r_busy       <= 1'b0;
                    end else if (w_tick_dec) begin
                        r_countdown <= r_countdown - 8'd1;
                    end
                end

                ST_CLEAN: begin
                    if (w_tick_last) begin
                        r_state      <= ST_STANDBY;
                        r_mode_state <= MODE_STANDBY;
                        r_countdown  <= 8'd0;
                        r_busy       <= 1'b0;
                        r_clean_done <= 1'b1;
                    end else if (w_tick_dec) begin
                        r_countdown <= r_countdown - 8'd1;
                    end
                end

                default: begin
                    r_state      <= ST_STANDBY;
                    r_mode_state <= MODE_STANDBY;
                    r_menu_led   <= 1'b0;
                    r_countdown  <= 8'd0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign mode_state = r_mode_state;
    assign menu_led   = r_menu_led;
    assign countdown  = r_countdown;
    assign busy       = r_busy;
    assign clean_done = r_clean_done;

endmodule

// File: tb/tb_hood_mode_scheduler.sv
// -----------------------------------------------------------------------------
// Bench for hood_mode_scheduler.
//
// The reference model tracks the fan as a display mode, an armed flag and a
// seconds counter. busy is derived from the counter being non-zero.
// A compare process checks every output on each falling edge.
// The directed sequence also checks hand-computed literals at key points.
// -----------------------------------------------------------------------------
module tb_hood_mode_scheduler;

    localparam int H_SEC = 60;
    localparam int E_SEC = 60;
    localparam int C_SEC = 180;

`ifdef HOOD_HURRICANE_ONCE_EN
    localparam bit ONCE_EN = 1'b1;
`else
    localparam bit ONCE_EN = 1'b0;
`endif

    // Button bundle order: {menu, mode1, mode2, mode3, clean}.
    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_MENU = 5'b10000;
    localparam logic [4:0] B_M1   = 5'b01000;
    localparam logic [4:0] B_M2   = 5'b00100;
    localparam logic [4:0] B_M3   = 5'b00010;
    localparam logic [4:0] B_CL   = 5'b00001;

    logic       clk;
    logic       rst;
    logic       tick_1hz;
    logic       power_on;
    logic       menu_btn, mode1_btn, mode2_btn, mode3_btn, clean_btn;
    logic [2:0] mode_state;
    logic       menu_led;
    logic [7:0] countdown;
    logic       busy;
    logic       hurricane_used;
    logic       clean_done;

    hood_mode_scheduler #(
        .HURRICANE_SEC(H_SEC),
        .EXIT_SEC     (E_SEC),
        .CLEAN_SEC    (C_SEC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick_1hz      (tick_1hz),
        .power_on      (power_on),
        .menu_btn      (menu_btn),
        .mode1_btn     (mode1_btn),
        .mode2_btn     (mode2_btn),
        .mode3_btn     (mode3_btn),
        .clean_btn     (clean_btn),
        .mode_state    (mode_state),
        .menu_led      (menu_led),
        .countdown     (countdown),
        .busy          (busy),
        .hurricane_used(hurricane_used),
        .clean_done    (clean_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_mode  = 0;   // displayed fan mode code 0..4
    bit m_exit  = 0;   // hurricane is counting down to standby
    bit m_armed = 0;
    int m_cnt   = 0;   // seconds left; non-zero means a timed phase is running
    bit m_used  = 0;
    bit m_done  = 0;
    bit [3:0] m_req;
    int m_pick;

    always @(posedge clk) begin
        m_done = 0;
        if (rst || !power_on) begin
            m_mode = 0; m_exit = 0; m_armed = 0; m_cnt = 0; m_used = 0;
        end else if (m_cnt > 0) begin
            if (m_mode == 3 && !m_exit && menu_btn) begin
                m_exit = 1;
                m_cnt  = E_SEC;
            end else if (tick_1hz) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    if (m_mode == 3 && !m_exit) begin
                        m_mode = 2;
                    end else begin
                        m_done = (m_mode == 4);
                        m_mode = 0;
                        m_exit = 0;
                    end
                end
            end
        end else begin
            // Requested target codes 1..4; the lowest code wins.
            m_req  = {clean_btn, mode3_btn && !(ONCE_EN && m_used), mode2_btn, mode1_btn};
            m_pick = 0;
            for (int i = 3; i >= 0; i--) if (m_req[i]) m_pick = i + 1;
            if (menu_btn) begin
                if (m_mode == 0) m_armed = !m_armed;
                else             m_mode  = 0;
            end else if ((m_mode == 0 && m_armed && m_pick != 0) ||
                         (m_mode != 0 && m_pick >= 1 && m_pick <= 3)) begin
                m_armed = 0;
                m_mode  = m_pick;
                if (m_pick == 3) begin m_cnt = H_SEC; m_used = 1; end
                if (m_pick == 4) m_cnt = C_SEC;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("mode_state",     32'(mode_state),     32'(m_mode));
            check("menu_led",       32'(menu_led),       32'(m_armed));
            check("countdown",      32'(countdown),      32'(m_cnt));
            check("busy",           32'(busy),           32'(m_cnt != 0));
            check("hurricane_used", 32'(hurricane_used), 32'(ONCE_EN && m_used));
            check("clean_done",     32'(clean_done),     32'(m_done));
        end
    end

    // ---------------- stimulus ----------------
    // Drives one active cycle of buttons/tick, then returns after the DUT
    // has reacted. Outputs are stable at the return point.
    task automatic step(input logic [4:0] b, input logic t);
        @(negedge clk);
        {menu_btn, mode1_btn, mode2_btn, mode3_btn, clean_btn} = b;
        tick_1hz = t;
        @(negedge clk);
        {menu_btn, mode1_btn, mode2_btn, mode3_btn, clean_btn} = B_NONE;
        tick_1hz = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(B_NONE, 1'b1);
    endtask

    task automatic power_cycle();
        @(negedge clk);
        power_on = 1'b0;
        @(negedge clk);
        check("pwr_off_mode", 32'(mode_state), 32'd0);
        check("pwr_off_used", 32'(hurricane_used), 32'd0);
        power_on = 1'b1;
    endtask

    initial begin
        rst = 1'b1; power_on = 1'b0; tick_1hz = 1'b0;
        {menu_btn, mode1_btn, mode2_btn, mode3_btn, clean_btn} = B_NONE;
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst_mode", 32'(mode_state), 32'd0);
        check("rst_led",  32'(menu_led),   32'd0);
        check("rst_cnt",  32'(countdown),  32'd0);
        check("rst_busy", 32'(busy),       32'd0);
        rst = 1'b0; power_on = 1'b1;

        // Menu-gated gear entry, then direct gear switch.
        step(B_MENU, 1'b0); check("arm_led", 32'(menu_led), 32'd1);
        step(B_M1, 1'b0);   check("gear1", 32'(mode_state), 32'd1);
        check("gear1_led", 32'(menu_led), 32'd0);
        step(B_M2, 1'b0);   check("gear2", 32'(mode_state), 32'd2);

        // Full hurricane run with fall-back to gear 2.
        step(B_MENU, 1'b0); check("gear_to_stby", 32'(mode_state), 32'd0);
        step(B_MENU, 1'b0);
        step(B_M3, 1'b0);   check("hurri_mode", 32'(mode_state), 32'd3);
        check("hurri_load", 32'(countdown), 32'd60);
        ticks(59);          check("hurri_last", 32'(countdown), 32'd1);
        ticks(1);           check("hurri_fallback", 32'(mode_state), 32'd2);
        check("hurri_cnt0", 32'(countdown), 32'd0);
        check("hurri_used", 32'(hurricane_used), 32'(ONCE_EN));
        step(B_M3, 1'b0);   check("mode3_again", 32'(mode_state), ONCE_EN ? 32'd2 : 32'd3);
        step(B_MENU, 1'b0);
        ticks(E_SEC);       check("back_stby", 32'(mode_state), 32'd0);
        step(B_MENU, 1'b0);
        step(B_M3, 1'b0);   check("stby_mode3", 32'(mode_state), ONCE_EN ? 32'd0 : 32'd3);
        check("stby_mode3_led", 32'(menu_led), ONCE_EN ? 32'd1 : 32'd0);
        power_cycle();

        // Hurricane exit after 10 s; buttons ignored during the exit delay.
        step(B_MENU, 1'b0);
        step(B_M3, 1'b0);
        ticks(10);          check("hurri_10s", 32'(countdown), 32'd50);
        step(B_MENU, 1'b0); check("exit_mode", 32'(mode_state), 32'd3);
        check("exit_load", 32'(countdown), 32'd60);
        step(B_M1, 1'b0); step(B_CL, 1'b0); step(B_MENU, 1'b0);
        step(B_M3, 1'b0); step(B_M2, 1'b0);
        check("exit_ignore", 32'(countdown), 32'd60);
        ticks(59);          check("exit_last", 32'(mode_state), 32'd3);
        ticks(1);           check("exit_done", 32'(mode_state), 32'd0);
        check("exit_busy", 32'(busy), 32'd0);

        // Menu on the expiring tick wins over the fall-back to gear 2.
        power_cycle();
        step(B_MENU, 1'b0);
        step(B_M3, 1'b0);
        ticks(59);
        step(B_MENU, 1'b1); check("menu_vs_tick", 32'(countdown), 32'd60);
        check("menu_vs_tick_mode", 32'(mode_state), 32'd3);
        ticks(E_SEC);

        // Self-clean; a tick in the entry cycle does not count.
        step(B_MENU, 1'b0);
        step(B_CL, 1'b1);   check("clean_mode", 32'(mode_state), 32'd4);
        check("clean_load", 32'(countdown), 32'd180);
        ticks(179);         check("clean_last", 32'(countdown), 32'd1);
        ticks(1);           check("clean_end", 32'(mode_state), 32'd0);
        check("clean_done_hi", 32'(clean_done), 32'd1);
        @(negedge clk);     check("clean_done_lo", 32'(clean_done), 32'd0);

        // Power loss mid-clean aborts without a done pulse.
        step(B_MENU, 1'b0);
        step(B_CL, 1'b0);
        ticks(130);         check("clean_50", 32'(countdown), 32'd50);
        @(negedge clk); power_on = 1'b0;
        @(negedge clk);
        check("abort_mode", 32'(mode_state), 32'd0);
        check("abort_cnt",  32'(countdown),  32'd0);
        check("abort_done", 32'(clean_done), 32'd0);
        check("abort_used", 32'(hurricane_used), 32'd0);
        power_on = 1'b1;

        // Simultaneous-button priorities.
        step(B_MENU, 1'b0);
        step(B_M2 | B_CL, 1'b0);      check("m2_over_clean", 32'(mode_state), 32'd2);
        step(B_MENU | B_M1, 1'b0);    check("menu_over_m1", 32'(mode_state), 32'd0);
        step(B_MENU, 1'b0);
        step(B_MENU | B_M1, 1'b0);    check("menu_toggle", 32'(menu_led), 32'd0);
        step(B_M1, 1'b0);             check("unarmed_m1", 32'(mode_state), 32'd0);
        step(B_MENU, 1'b0);
        step(B_M1 | B_M2 | B_M3, 1'b0); check("m1_first", 32'(mode_state), 32'd1);
        step(B_CL, 1'b0);             check("gear_clean_ign", 32'(mode_state), 32'd1);
        step(B_M3, 1'b0);             check("gear_to_hurri", 32'(mode_state), 32'd3);
        ticks(5);                     check("hurri_55", 32'(countdown), 32'd55);

        // Reset in the middle of a hurricane run.
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("mid_rst_mode", 32'(mode_state), 32'd0);
        check("mid_rst_cnt",  32'(countdown),  32'd0);
        check("mid_rst_busy", 32'(busy),       32'd0);
        check("mid_rst_used", 32'(hurricane_used), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
